uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
- UART transmit framer. Accepts a parallel byte over a valid/ready handshake and serialises it onto tx_out as one frame: start bit, then 5-8 data bits LSB first, then an optional parity bit, then 1 or 2 stop bits.
- Contains its own baud tick counter and data-bit counter. The data-bit count follows the same encoding as the UART bit counter: data bits = 5 + no_of_bits.
- Sits between the core-side TX interface and the serial pin.

Parameters:
- DIV_W, 16, width of baud divisor and baud counter.
- DATA_W, 8, parallel data width (maximum data bits per frame).

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  DATA_W  byte to send; bits above the configured data length are ignored.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  framer can accept a byte.
- no_of_bits  in  2  data length code: 0 = 5, 1 = 6, 2 = 7, 3 = 8 bits.
- two_stop  in  1  1 = two stop bits, 0 = one stop bit.
- baud_div  in  DIV_W  bit period minus one, in clock cycles.
- tx_out  out  1  serial line; idles high.
- tx_busy  out  1  a frame is in progress.

Behaviour:
- Reset (synchronous, active-high):
  - State IDLE; tx_out=1, tx_ready=1, tx_busy=0.
  - Baud counter, bit counter and shift register cleared.
- Accept: a byte is accepted on a rising edge where tx_valid && tx_ready.
  - On that edge: latch tx_data into the shift register; latch no_of_bits, two_stop and baud_div; enter START.
  - Config changes mid-frame have no effect.
- States: IDLE -> START -> DATA -> (PARITY) -> STOP1 -> (STOP2) -> IDLE.
- Bit timing:
  - Each non-IDLE state lasts exactly baud_div+1 cycles.
  - The baud counter counts 0..baud_div and restarts at 0 on every state change.
  - Bit end = baud counter == latched baud_div.
  - baud_div=0 gives a 1-cycle bit.
- Latency: tx_out drops to 0 in the first cycle after the accept edge.
- START: tx_out=0.
- DATA:
  - tx_out = shift register bit 0.
  - At each bit end: shift right by one and increment the bit counter (3 bits).
  - Leave DATA when the bit counter == latched no_of_bits + 4 at a bit end; clear the counter on exit.
- STOP1 / STOP2: tx_out=1. STOP2 is entered only if the latched two_stop=1.
- End of frame:
  - At the bit end of the last stop bit, go to IDLE; tx_ready=1 from the next cycle.
  - Back-to-back frame: if tx_valid is held, the next byte is accepted on the first IDLE cycle. There is therefore exactly one IDLE cycle of high line between frames.
- Handshake status:
  - tx_ready=1 only in IDLE.
  - tx_busy=1 in every non-IDLE state.
  - tx_valid outside IDLE is ignored; no byte is lost because ready is low.
- Outputs are registered; no combinational path from tx_valid to tx_out.
- Reset mid-frame: the next edge returns to IDLE with tx_out=1 and the frame is discarded. The line may show a truncated frame; this is acceptable.
- Simultaneous reset and tx_valid: reset wins and the byte is not accepted.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - Adds inputs parity_en (1) and parity_odd (1), both latched at accept.
  - If the latched parity_en=1, a PARITY state sits between DATA and STOP1 and drives XOR of the sent data bits, inverted if parity_odd=1.
  - Parity accumulates during DATA (shift register bit 0 XORed in at each bit end) and lasts one bit period.
- When not defined: no parity ports, no PARITY state, DATA goes directly to STOP1.

Decomposition:
- Package uart_pkg holds:
  - enum tx_state_e {IDLE, START, DATA, PARITY, STOP1, STOP2}.
  - Constant MIN_DATA_BITS=5 and the no_of_bits encoding.
  - Localparam for the 3-bit counter width.
- One natural sub-module: uart_baud_tick (counter with restart input, tick output). The bit counter stays inline.

Test Plan:
- Reset, baud_div=3, no_of_bits=3, two_stop=0, tx_data=8'hA5 -> tx_out over 40 cycles: 0, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1; tx_ready high again at cycle 41.
- no_of_bits=0, tx_data=8'hFF, baud_div=0 -> frame 0,1,1,1,1,1,1, i.e. 5 data bits, 7 cycles total; bits 7:5 not sent.
- two_stop=1, back-to-back tx_valid with 8'h00 then 8'h01 -> two stop periods, one idle-high cycle, second start bit; tx_ready pulses for exactly one cycle.
- Change baud_div from 3 to 10 and no_of_bits mid-frame -> current frame timing and length unchanged; next frame uses the new values.
- reset asserted in the 3rd data bit -> next cycle tx_out=1, tx_ready=1, tx_busy=0; a following byte frames correctly.
- With UART_TX_PARITY_EN, parity_en=1, parity_odd=0, 8-bit 8'h07 -> parity bit 1; parity_odd=1 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit framer.
// Data length code: data bits = MIN_DATA_BITS + no_of_bits (0..3 -> 5..8 bits).
package uart_pkg;

   localparam int MIN_DATA_BITS = 5;
   localparam int BIT_CNT_W     = 3;

   typedef enum logic [1:0] {
      NB_5 = 2'd0,
      NB_6 = 2'd1,
      NB_7 = 2'd2,
      NB_8 = 2'd3
   } nb_code_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP1  = 3'd4,
      STOP2  = 3'd5
   } tx_state_e;

   // Bit-counter value of the final data bit for a given length code.
   function automatic logic [BIT_CNT_W-1:0] last_bit_idx(input logic [1:0] nb);
      return {1'b0, nb} + BIT_CNT_W'(MIN_DATA_BITS - 1);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..div and flags the last cycle of the period.
// The owner restarts it whenever a new bit period begins.
module uart_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             restart,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] count;

   // Cycle counter within the current bit period.
   always_ff @(posedge clock) begin
      if (reset || restart) count <= '0;
      else                  count <= count + DIV_W'(1);
   end

   assign tick = (count == div);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, 5-8 data bits LSB first, optional parity,
// one or two stop bits. Optional parity support is built when the macro
// UART_TX_PARITY_EN is defined.
// Handshake: a byte transfers on a rising edge with tx_valid && tx_ready;
// tx_ready is high only while idle, and tx_valid is ignored otherwise.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DIV_W  = 16,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [1:0]        no_of_bits,
   input  logic              two_stop,
   input  logic [DIV_W-1:0]  baud_div,
`ifdef UART_TX_PARITY_EN
   input  logic              parity_en,
   input  logic              parity_odd,
`endif
   output logic              tx_out,
   output logic              tx_busy
);

   tx_state_e             state, state_nxt;
   logic [DATA_W-1:0]     shift_q, shift_nxt;
   logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
   logic                  parity_acc, parity_nxt;
   logic [1:0]            nb_q;
   logic                  two_stop_q;
   logic [DIV_W-1:0]      div_q;
   logic                  par_en_q, par_odd_q;
   logic                  tick;
   logic                  accept;
   logic                  tx_out_nxt;

   assign accept = (state == IDLE) && tx_valid;

   // Every bit period starts from zero; idle holds the counter cleared.
   uart_baud_tick #(.DIV_W(DIV_W)) u_baud (
      .clock   (clock),
      .reset   (reset),
      .restart ((state == IDLE) || tick),
      .div     (div_q),
      .tick    (tick)
   );

`ifdef UART_TX_PARITY_EN
   // Parity options are frozen for the frame at accept.
   always_ff @(posedge clock) begin
      if (reset) begin
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
      end else if (accept) begin
         par_en_q  <= parity_en;
         par_odd_q <= parity_odd;
      end
   end
`else
   assign par_en_q  = 1'b0;
   assign par_odd_q = 1'b0;
`endif

   // State, datapath, latched configuration and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         shift_q    <= '0;
         bit_cnt    <= '0;
         parity_acc <= 1'b0;
         nb_q       <= '0;
         two_stop_q <= 1'b0;
         div_q      <= '0;
         tx_out     <= 1'b1;
         tx_ready   <= 1'b1;
         tx_busy    <= 1'b0;
      end else begin
         state      <= state_nxt;
         shift_q    <= shift_nxt;
         bit_cnt    <= bit_cnt_nxt;
         parity_acc <= parity_nxt;
         if (accept) begin
            nb_q       <= no_of_bits;
            two_stop_q <= two_stop;
            div_q      <= baud_div;
         end
         tx_out     <= tx_out_nxt;
         tx_ready   <= (state_nxt == IDLE);
         tx_busy    <= (state_nxt != IDLE);
      end
   end

   // Next state plus shift register, bit counter and parity accumulator.
   always_comb begin
      state_nxt   = state;
      shift_nxt   = shift_q;
      bit_cnt_nxt = bit_cnt;
      parity_nxt  = parity_acc;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt   = START;
               shift_nxt   = tx_data;
               bit_cnt_nxt = '0;
               parity_nxt  = 1'b0;
            end
         end
         START: begin
            if (tick) state_nxt = DATA;
         end
         DATA: begin
            if (tick) begin
               shift_nxt  = shift_q >> 1;
               parity_nxt = parity_acc ^ shift_q[0];
               if (bit_cnt == last_bit_idx(nb_q)) begin
                  bit_cnt_nxt = '0;
                  state_nxt   = par_en_q ? PARITY : STOP1;
               end else begin
                  bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
               end
            end
         end
         PARITY: begin
            if (tick) state_nxt = STOP1;
         end
         STOP1: begin
            if (tick) state_nxt = two_stop_q ? STOP2 : IDLE;
         end
         STOP2: begin
            if (tick) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Line level for the upcoming cycle, registered above.
   always_comb begin
      tx_out_nxt = 1'b1;
      case (state_nxt)
         START:   tx_out_nxt = 1'b0;
         DATA:    tx_out_nxt = shift_nxt[0];
         PARITY:  tx_out_nxt = parity_nxt ^ par_odd_q;
         default: tx_out_nxt = 1'b1;
      endcase
   end

endmodule
